// File: rtl/banco_reg_multi_if.sv
// Bus bundle for banco_reg_multi: two write ports, two read ports, clear control.
// master drives writes/reads/clear; slave (the register file) returns read data,
// busy and conflict.
interface banco_reg_multi_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);
  logic              write0;
  logic [ADDR_W-1:0] regwriteaddress0;
  logic [DATA_W-1:0] datain0;
  logic              write1;
  logic [ADDR_W-1:0] regwriteaddress1;
  logic [DATA_W-1:0] datain1;
  logic [ADDR_W-1:0] regreader1;
  logic [ADDR_W-1:0] regreader2;
  logic [DATA_W-1:0] dataout1;
  logic [DATA_W-1:0] dataout2;
  logic              clear;
  logic              busy;
  logic              conflict;

  modport master (
    output write0, regwriteaddress0, datain0,
    output write1, regwriteaddress1, datain1,
    output regreader1, regreader2, clear,
    input  dataout1, dataout2, busy, conflict
  );

  modport slave (
    input  write0, regwriteaddress0, datain0,
    input  write1, regwriteaddress1, datain1,
    input  regreader1, regreader2, clear,
    output dataout1, dataout2, busy, conflict
  );
endinterface

// File: rtl/banco_reg_multi.sv
// Multi-ported register file: 2 write ports (port 1 wins on equal address),
// 2 combinational read ports with optional write bypass, optional hardwired
// register 0, and a sequential clear engine that zeroes one register per cycle.
// Ports: clock, reset (async, active-high), bus (banco_reg_multi_if.slave).
module banco_reg_multi #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic              clock,
  input logic              reset,
  banco_reg_multi_if.slave bus
);
  localparam int unsigned       NREGS    = 1 << ADDR_W;
  localparam logic [0:0]        S_IDLE   = 1'b0;
  localparam logic [0:0]        S_CLEAR  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              busy_q, busy_d;
  logic              conflict_q, conflict_d;
  logic              we0, we1;
  logic [DATA_W-1:0] rd1_c, rd2_c;

  // Effective write enables; blocked while clearing or in reset, and writes to
  // register 0 vanish when it is hardwired.
  assign we0 = bus.write0 && !busy_q && !reset &&
               !((ZERO_REG != 0) && (bus.regwriteaddress0 == '0));
  assign we1 = bus.write1 && !busy_q && !reset &&
               !((ZERO_REG != 0) && (bus.regwriteaddress1 == '0));

  // Read port 1: stored value, then bypass (port 1 over port 0), zero-reg last.
  always_comb begin
    rd1_c = regs_q[bus.regreader1];
    if ((BYPASS != 0) && we0 && (bus.regreader1 == bus.regwriteaddress0)) rd1_c = bus.datain0;
    if ((BYPASS != 0) && we1 && (bus.regreader1 == bus.regwriteaddress1)) rd1_c = bus.datain1;
    if ((ZERO_REG != 0) && (bus.regreader1 == '0)) rd1_c = '0;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2_c = regs_q[bus.regreader2];
    if ((BYPASS != 0) && we0 && (bus.regreader2 == bus.regwriteaddress0)) rd2_c = bus.datain0;
    if ((BYPASS != 0) && we1 && (bus.regreader2 == bus.regwriteaddress1)) rd2_c = bus.datain1;
    if ((ZERO_REG != 0) && (bus.regreader2 == '0)) rd2_c = '0;
  end

  // Next-state: storage writes, clear FSM, busy and conflict flags.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    regs_d    = regs_q;

    // Port 1 applied second so it overrides port 0 on the same address.
    if (we0) regs_d[bus.regwriteaddress0] = bus.datain0;
    if (we1) regs_d[bus.regwriteaddress1] = bus.datain1;

    case (state_q)
      S_IDLE: begin
        if (bus.clear) begin
          state_d   = S_CLEAR;
          clr_idx_d = '0;
        end
      end
      S_CLEAR: begin
        regs_d[clr_idx_q] = '0;
        // Exit on the last index so the counter never wraps.
        if (clr_idx_q == LAST_IDX) begin
          state_d   = S_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d == S_CLEAR);
    conflict_d = bus.write0 && bus.write1 && !busy_q &&
                 (bus.regwriteaddress0 == bus.regwriteaddress1);
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      clr_idx_q  <= '0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      regs_q     <= regs_d;
    end
  end

  assign bus.dataout1 = rd1_c;
  assign bus.dataout2 = rd2_c;
  assign bus.busy     = busy_q;
  assign bus.conflict = conflict_q;
endmodule

// File: tb/tb_banco_reg_multi.sv
// Bench for banco_reg_multi: three instances (default, no-bypass, no-zero-reg)
// share one stimulus; expectations are queued by the stimulus and checked by a
// negedge monitor.
module tb_banco_reg_multi;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;

  localparam int K_A_D1   = 0;
  localparam int K_A_D2   = 1;
  localparam int K_A_BUSY = 2;
  localparam int K_A_CONF = 3;
  localparam int K_B_D1   = 4;
  localparam int K_C_D1   = 5;

  localparam int unsigned TIMEOUT_CYCLES = 5000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w0 = 1'b0, w1 = 1'b0, clr = 1'b0;
  logic [AW-1:0] wa0 = '0, wa1 = '0, ra1 = '0, ra2 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          done = 1'b0;

  always #5 clk = ~clk;

  banco_reg_multi_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
  banco_reg_multi_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();
  banco_reg_multi_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

  assign ifa.write0 = w0;            assign ifb.write0 = w0;            assign ifc.write0 = w0;
  assign ifa.regwriteaddress0 = wa0; assign ifb.regwriteaddress0 = wa0; assign ifc.regwriteaddress0 = wa0;
  assign ifa.datain0 = d0;           assign ifb.datain0 = d0;           assign ifc.datain0 = d0;
  assign ifa.write1 = w1;            assign ifb.write1 = w1;            assign ifc.write1 = w1;
  assign ifa.regwriteaddress1 = wa1; assign ifb.regwriteaddress1 = wa1; assign ifc.regwriteaddress1 = wa1;
  assign ifa.datain1 = d1;           assign ifb.datain1 = d1;           assign ifc.datain1 = d1;
  assign ifa.regreader1 = ra1;       assign ifb.regreader1 = ra1;       assign ifc.regreader1 = ra1;
  assign ifa.regreader2 = ra2;       assign ifb.regreader2 = ra2;       assign ifc.regreader2 = ra2;
  assign ifa.clear = clr;            assign ifb.clear = clr;            assign ifc.clear = clr;

  banco_reg_multi #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clock(clk), .reset(rst), .bus(ifa));
  banco_reg_multi #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clock(clk), .reset(rst), .bus(ifb));
  banco_reg_multi #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(1)) dut_c (
    .clock(clk), .reset(rst), .bus(ifc));

  typedef struct {
    int            kind;
    logic [DW-1:0] exp;
    int            tag;
  } item_t;

  item_t sb[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic logic [DW-1:0] actual(input int kind);
    case (kind)
      K_A_D1:   return ifa.dataout1;
      K_A_D2:   return ifa.dataout2;
      K_A_BUSY: return DW'(ifa.busy);
      K_A_CONF: return DW'(ifa.conflict);
      K_B_D1:   return ifb.dataout1;
      default:  return ifc.dataout1;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_A_D1:   return "a_dataout1";
      K_A_D2:   return "a_dataout2";
      K_A_BUSY: return "a_busy";
      K_A_CONF: return "a_conflict";
      K_B_D1:   return "nobypass_dataout1";
      default:  return "nozero_dataout1";
    endcase
  endfunction

  // Monitor: everything queued during a cycle is compared at that cycle's negedge.
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      item_t         it;
      logic [DW-1:0] act;
      it  = sb.pop_front();
      act = actual(it.kind);
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s tag=%0d got=%h exp=%h", kname(it.kind), it.tag, act, it.exp);
      end
    end
  end

  // Watchdog: stimulus must finish within the cycle budget.
  initial begin
    repeat (TIMEOUT_CYCLES) @(posedge clk);
    if (!done) begin
      failures++;
      $display("FAIL timeout after %0d cycles", TIMEOUT_CYCLES);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input logic [DW-1:0] exp, input int tag);
    item_t it;
    it.kind = kind;
    it.exp  = exp;
    it.tag  = tag;
    sb.push_back(it);
  endtask

  task automatic check_now(input int kind, input logic [DW-1:0] exp, input int tag);
    logic [DW-1:0] act;
    act = actual(kind);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL now %s tag=%0d got=%h exp=%h", kname(kind), tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return 64'hA5A5_0000_0000_0000 | DW'(i);
  endfunction

  // Contents expected just before the clear sweep in the clear scenario.
  function automatic logic [DW-1:0] fill_val(input int i);
    if (i == 0) return '0;
    if (i == 5) return 64'hBEEF;
    return pat(i);
  endfunction

  initial begin
    // Reset state
    ra1 = AW'(5);
    #2;
    check_now(K_A_BUSY, 0, 90);
    check_now(K_A_CONF, 0, 91);
    check_now(K_A_D1,   0, 92);
    expect_v(K_A_BUSY, 0, 100);
    expect_v(K_A_CONF, 0, 101);
    expect_v(K_A_D1,   0, 102);
    expect_v(K_B_D1,   0, 103);
    step();
    rst = 1'b0;

    // Fill reg[i] = i through port 0, then read both ports crosswise
    for (int i = 1; i < 32; i++) begin
      step();
      w0 = 1'b1; wa0 = AW'(i); d0 = DW'(i);
    end
    step();
    w0 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = AW'(i); ra2 = AW'(31 - i);
      expect_v(K_A_D1, DW'(i), 110 + i);
      expect_v(K_A_D2, DW'(31 - i), 150 + i);
      step();
    end

    // Same-address dual write: port 1 wins, conflict pulses one cycle
    w0 = 1'b1; wa0 = AW'(7); d0 = 64'hAA;
    w1 = 1'b1; wa1 = AW'(7); d1 = 64'h55;
    ra1 = AW'(7);
    expect_v(K_A_D1, 64'h55, 200);
    expect_v(K_A_CONF, 0, 201);
    expect_v(K_B_D1, 64'h7, 202);
    step();
    w0 = 1'b0; w1 = 1'b0;
    expect_v(K_A_D1, 64'h55, 203);
    expect_v(K_A_CONF, 1, 204);
    expect_v(K_B_D1, 64'h55, 205);
    step();
    expect_v(K_A_CONF, 0, 206);
    step();
    // Distinct addresses: both land, no conflict
    w0 = 1'b1; wa0 = AW'(3); d0 = 64'h33;
    w1 = 1'b1; wa1 = AW'(4); d1 = 64'h44;
    ra1 = AW'(3); ra2 = AW'(4);
    expect_v(K_A_D1, 64'h33, 210);
    expect_v(K_A_D2, 64'h44, 211);
    step();
    w0 = 1'b0; w1 = 1'b0;
    expect_v(K_A_CONF, 0, 212);
    expect_v(K_A_D1, 64'h33, 213);
    expect_v(K_A_D2, 64'h44, 214);

    // Bypass vs no bypass on reg 9
    step();
    w0 = 1'b1; wa0 = AW'(9); d0 = 64'h1234; ra1 = AW'(9);
    expect_v(K_A_D1, 64'h1234, 300);
    expect_v(K_B_D1, 64'h9, 301);
    step();
    w0 = 1'b0;
    expect_v(K_B_D1, 64'h1234, 302);

    // Register 0: hardwired vs writable
    step();
    w0 = 1'b1; wa0 = '0; d0 = 64'hFF; ra1 = '0;
    expect_v(K_A_D1, 0, 400);
    expect_v(K_C_D1, 64'hFF, 401);
    step();
    w0 = 1'b0;
    expect_v(K_A_D1, 0, 402);
    expect_v(K_C_D1, 64'hFF, 403);

    // Fill every register, then clear with a simultaneous write to reg 5
    for (int k = 0; k < 16; k++) begin
      step();
      w0 = 1'b1; wa0 = AW'(2 * k);     d0 = pat(2 * k);
      w1 = 1'b1; wa1 = AW'(2 * k + 1); d1 = pat(2 * k + 1);
    end
    step();
    w0 = 1'b1; wa0 = AW'(5); d0 = 64'hBEEF; w1 = 1'b0; clr = 1'b1;
    expect_v(K_A_BUSY, 0, 500);
    for (int k = 1; k <= 33; k++) begin
      step();
      w0 = 1'b0; clr = 1'b0;
      if (k == 3) begin
        w0 = 1'b1; wa0 = AW'(1); d0 = 64'hDEAD;
      end
      if (k == 10) clr = 1'b1;
      expect_v(K_A_BUSY, (k <= 32) ? 1 : 0, 500 + k);
      if (k <= 32) begin
        ra2 = AW'(k - 1);
        expect_v(K_A_D2, fill_val(k - 1), 540 + k);
      end
      if (k >= 2) begin
        ra1 = AW'(k - 2);
        expect_v(K_A_D1, 0, 580 + k);
      end
    end
    for (int i = 0; i < 32; i++) begin
      step();
      ra1 = AW'(i); ra2 = AW'(31 - i);
      expect_v(K_A_D1, 0, 620 + i);
      expect_v(K_A_D2, 0, 660 + i);
    end

    // Reset asserted between edges in the middle of a clear
    step();
    w0 = 1'b1; wa0 = AW'(10); d0 = 64'h1010;
    w1 = 1'b1; wa1 = AW'(11); d1 = 64'h1111;
    step();
    w0 = 1'b0; w1 = 1'b0; clr = 1'b1; ra1 = AW'(10); ra2 = AW'(11);
    expect_v(K_A_D1, 64'h1010, 700);
    expect_v(K_A_D2, 64'h1111, 701);
    expect_v(K_A_BUSY, 0, 702);
    step();
    clr = 1'b0;
    step();
    step();
    expect_v(K_A_BUSY, 1, 703);
    expect_v(K_A_D1, 64'h1010, 704);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_now(K_A_BUSY, 0, 720);
    check_now(K_A_D1,   0, 721);
    check_now(K_A_D2,   0, 722);
    expect_v(K_A_BUSY, 0, 705);
    expect_v(K_A_D1, 0, 706);
    expect_v(K_A_D2, 0, 707);
    expect_v(K_A_CONF, 0, 708);
    expect_v(K_C_D1, 0, 709);
    step();
    w0 = 1'b1; wa0 = AW'(12); d0 = 64'hABCD; clr = 1'b1; ra1 = AW'(12);
    expect_v(K_A_D1, 0, 710);
    expect_v(K_A_BUSY, 0, 711);
    step();
    w0 = 1'b0; clr = 1'b0; rst = 1'b0;
    expect_v(K_A_D1, 0, 712);
    expect_v(K_A_BUSY, 0, 713);
    step();
    expect_v(K_A_BUSY, 0, 714);
    expect_v(K_A_D2, 0, 715);
    step();
    step();

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard not drained: %0d pending", sb.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
